// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI clock engine and its helpers.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_CLKS_PER_HALF_BIT = 2;
  localparam int DEF_DATA_WIDTH        = 8;

  // Bits needed to hold a counter that runs 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_clk_pipe.sv
// SYNC_STAGES-deep register chain that carries the internal SPI clock to the pin.
module spi_clk_pipe #(
  parameter int SYNC_STAGES = 2,
  parameter bit CPOL        = 1'b0
) (
  input  logic i_clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_pipe;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_pipe <= {SYNC_STAGES{CPOL}};
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master timing core: captures a byte on trigger and generates one
// 2*DATA_WIDTH-edge SPI clock burst with leading/trailing strobes.
module spi_sclk_engine
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = DEF_CLKS_PER_HALF_BIT,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter bit CPOL              = 1'b0,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  trigger,
  input  logic [DATA_WIDTH-1:0] i_byte,
  output logic [DATA_WIDTH-1:0] r_byte,
  output logic                  busy,
  output logic                  leading_edge,
  output logic                  trailing_edge,
  output logic                  data_ready,
  output logic                  r_spi_clk,
  output logic                  o_spi_clk
);

  localparam int HW = cnt_width(CLKS_PER_HALF_BIT);
  localparam int EW = cnt_width(2 * DATA_WIDTH);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_WIDTH - 1);

  state_t                r_state, w_state_next;
  logic [HW-1:0]         r_half_cnt, w_half_next;
  logic [EW-1:0]         r_edge_cnt, w_edge_next;
  logic [DATA_WIDTH-1:0] w_byte_next;
  logic                  w_spi_clk_next, w_lead_next, w_trail_next, w_ready_next;
  logic                  w_start;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_half_cnt    <= '0;
      r_edge_cnt    <= '0;
      r_byte        <= '0;
      r_spi_clk     <= CPOL;
      leading_edge  <= 1'b0;
      trailing_edge <= 1'b0;
      data_ready    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_half_cnt    <= w_half_next;
      r_edge_cnt    <= w_edge_next;
      r_byte        <= w_byte_next;
      r_spi_clk     <= w_spi_clk_next;
      leading_edge  <= w_lead_next;
      trailing_edge <= w_trail_next;
      data_ready    <= w_ready_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_half_next    = r_half_cnt;
    w_edge_next    = r_edge_cnt;
    w_byte_next    = r_byte;
    w_spi_clk_next = r_spi_clk;
    w_lead_next    = 1'b0;
    w_trail_next   = 1'b0;
    w_ready_next   = 1'b0;
    w_start        = 1'b0;

    case (r_state)
      IDLE: begin
        w_start = trigger;
      end
      RUN: begin
        if (r_half_cnt == HALF_LAST) begin
          w_half_next    = '0;
          w_edge_next    = r_edge_cnt + 1'b1;
          w_spi_clk_next = ~r_spi_clk;
          // Edge numbers start at 1, so an even count before the edge means odd (leading).
          w_lead_next    = ~r_edge_cnt[0];
          w_trail_next   = r_edge_cnt[0];
          if (r_edge_cnt == EDGE_LAST) begin
            w_ready_next   = 1'b1;
            w_state_next   = IDLE;
            w_edge_next    = '0;
            w_spi_clk_next = CPOL;
            // Accepting here lets bursts run back to back without dropping busy.
            w_start        = trigger;
          end
        end else begin
          w_half_next = r_half_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_start) begin
      w_state_next   = RUN;
      w_half_next    = '0;
      w_edge_next    = '0;
      w_byte_next    = i_byte;
      w_spi_clk_next = CPOL;
    end
  end

  assign busy = (r_state == RUN);

  spi_clk_pipe #(
    .SYNC_STAGES (SYNC_STAGES),
    .CPOL        (CPOL)
  ) u_clk_pipe (
    .i_clk (i_clk),
    .reset (reset),
    .i_d   (r_spi_clk),
    .o_q   (o_spi_clk)
  );

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Bench for spi_sclk_engine: unit A (H=2, CPOL=0) and unit B (H=1, CPOL=1)
// checked every cycle against a cycle-count reference model.
module tb_spi_sclk_engine;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int HP [2] = '{2, 1};
  localparam int CP [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       trg [2];
  logic [7:0] ib  [2];
  logic [7:0] rb  [2];
  logic       bsy [2], le [2], te [2], dr [2], rclk [2], oclk [2];

  spi_sclk_engine #(.CLKS_PER_HALF_BIT(2), .DATA_WIDTH(DW), .CPOL(1'b0), .SYNC_STAGES(S)) u_a (
    .i_clk(clk), .reset(rst[0]), .trigger(trg[0]), .i_byte(ib[0]), .r_byte(rb[0]),
    .busy(bsy[0]), .leading_edge(le[0]), .trailing_edge(te[0]), .data_ready(dr[0]),
    .r_spi_clk(rclk[0]), .o_spi_clk(oclk[0]));

  spi_sclk_engine #(.CLKS_PER_HALF_BIT(1), .DATA_WIDTH(DW), .CPOL(1'b1), .SYNC_STAGES(S)) u_b (
    .i_clk(clk), .reset(rst[1]), .trigger(trg[1]), .i_byte(ib[1]), .r_byte(rb[1]),
    .busy(bsy[1]), .leading_edge(le[1]), .trailing_edge(te[1]), .data_ready(dr[1]),
    .r_spi_clk(rclk[1]), .o_spi_clk(oclk[1]));

  // Model: m_n counts cycles since the accepting edge; edge e happens at m_n = e*H.
  bit         m_act  [2];
  int         m_n    [2];
  logic [7:0] m_byte [2];
  logic       m_clk  [2], m_le [2], m_te [2], m_dr [2];
  logic       m_hist [2][S+1];

  int n_pass  = 0;
  int n_total = 0;
  int c_dr [2], c_le [2], c_te [2], c_rise [2];
  logic prev_clk [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge(input int d);
    bit was, fin;
    int e;
    m_le[d] = 1'b0; m_te[d] = 1'b0; m_dr[d] = 1'b0;
    if (rst[d]) begin
      m_act[d] = 1'b0; m_n[d] = 0; m_byte[d] = 8'h00;
      m_clk[d] = CP[d][0];
      for (int i = 0; i <= S; i++) m_hist[d][i] = CP[d][0];
      return;
    end
    was = m_act[d]; fin = 1'b0;
    if (was) begin
      m_n[d]++;
      if (m_n[d] % HP[d] == 0) begin
        e = m_n[d] / HP[d];
        if (e % 2 == 1) m_le[d] = 1'b1; else m_te[d] = 1'b1;
        if (e == 2 * DW) begin
          m_dr[d] = 1'b1; m_act[d] = 1'b0; fin = 1'b1;
          $display("burst %0d done byte=%02h", d, m_byte[d]);
        end
      end
    end
    if (trg[d] && (!was || fin)) begin
      m_act[d] = 1'b1; m_n[d] = 0; m_byte[d] = ib[d];
    end
    if (m_act[d]) m_clk[d] = ((CP[d] + m_n[d] / HP[d]) % 2) == 1;
    else          m_clk[d] = CP[d][0];
    for (int i = S; i > 0; i--) m_hist[d][i] = m_hist[d][i-1];
    m_hist[d][0] = m_clk[d];
  endtask

  task automatic check_unit(input int d);
    string nm;
    nm = (d == 0) ? "A" : "B";
    chk({nm, ".r_byte"},   rb[d],   m_byte[d]);
    chk({nm, ".busy"},     bsy[d],  m_act[d]);
    chk({nm, ".leading"},  le[d],   m_le[d]);
    chk({nm, ".trailing"}, te[d],   m_te[d]);
    chk({nm, ".ready"},    dr[d],   m_dr[d]);
    chk({nm, ".r_spi"},    rclk[d], m_clk[d]);
    chk({nm, ".o_spi"},    oclk[d], m_hist[d][S]);
    c_dr[d] += int'(dr[d]);
    c_le[d] += int'(le[d]);
    c_te[d] += int'(te[d]);
    if (rclk[d] && !prev_clk[d]) c_rise[d]++;
    prev_clk[d] = rclk[d];
  endtask

  task automatic clr_counts();
    for (int d = 0; d < 2; d++) begin
      c_dr[d] = 0; c_le[d] = 0; c_te[d] = 0; c_rise[d] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    trg[0] = 1'b0; trg[1] = 1'b0;
    check_unit(0);
    check_unit(1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; trg[d] = 1'b1; ib[d] = 8'hFF;
      prev_clk[d] = CP[d][0];
    end
    clr_counts();

    // Reset held with trigger high
    for (int k = 0; k < 3; k++) begin
      trg[0] = 1'b1; trg[1] = 1'b1;
      step();
    end
    chk("reset.r_byte", rb[0], 8'h00);
    chk("reset.o_spi",  oclk[0], 1'b0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // Basic burst, ignored retrigger at T+10, back-to-back trigger sampled at T+32
    clr_counts();
    prev_clk[0] = rclk[0];
    ib[0] = 8'hA5; trg[0] = 1'b1;
    step();
    chk("basic.r_byte", rb[0], 8'hA5);
    for (int k = 1; k <= 32; k++) begin
      if (k == 10) begin ib[0] = 8'h3C; trg[0] = 1'b1; end
      if (k == 32) begin ib[0] = 8'h5A; trg[0] = 1'b1; end
      step();
      if (k == 4)  chk("basic.o_spi_first_rise", oclk[0], 1'b1);
      if (k == 31) chk("retrig.r_byte", rb[0], 8'hA5);
    end
    chk("basic.ready_count", c_dr[0], 1);
    chk("basic.rises",       c_rise[0], 8);
    chk("basic.leads",       c_le[0], 8);
    chk("basic.trails",      c_te[0], 8);
    chk("b2b.r_byte",        rb[0], 8'h5A);
    chk("b2b.busy",          bsy[0], 1'b1);

    // Second burst: leading edge two cycles in, then reset at T'+13
    clr_counts();
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 2) chk("b2b.first_lead", le[0], 1'b1);
    end
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("mid.busy",  bsy[0], 1'b0);
    chk("mid.r_spi", rclk[0], 1'b0);
    for (int k = 0; k < 4; k++) step();
    chk("mid.ready_count", c_dr[0], 0);

    // Fresh burst after the abort
    clr_counts();
    ib[0] = 8'($urandom); trg[0] = 1'b1;
    step();
    for (int k = 1; k <= 34; k++) step();
    chk("fresh.leads",  c_le[0], 8);
    chk("fresh.trails", c_te[0], 8);
    chk("fresh.ready",  c_dr[0], 1);
    chk("fresh.rises",  c_rise[0], 8);

    // H=1, CPOL=1 burst
    clr_counts();
    ib[1] = 8'($urandom); trg[1] = 1'b1;
    step();
    chk("h1.idle_high", rclk[1], 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 1)  chk("h1.first_fall", rclk[1], 1'b0);
      if (k == 16) chk("h1.ready_at_16", dr[1], 1'b1);
    end
    chk("h1.leads",  c_le[1], 8);
    chk("h1.trails", c_te[1], 8);
    chk("h1.busy",   bsy[1], 1'b0);

    // Random triggers, bytes and occasional resets on both units
    for (int k = 0; k < 1500; k++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom_range(0, 99) == 0);
        trg[d] = ($urandom_range(0, 5) == 0);
        ib[d]  = 8'($urandom);
      end
      step();
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
